// File: rtl/mest_pro_mux_display_if.sv
// Bus bundle for the MESTPro multiplexed seven-segment display driver.
// The master side (board controller) drives the value/control inputs;
// the slave side (display driver) returns the scanned digit outputs.
interface mest_pro_mux_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_WIDTH  = 7
);

  logic                    i_output_enable;
  logic                    i_load;
  logic [NUM_DIGITS*4-1:0] i_value;
  logic [NUM_DIGITS-1:0]   i_dp_mask;
  logic                    i_blank_lz;
  logic [SEG_WIDTH-1:0]    o_segments;
  logic                    o_dp;
  logic [NUM_DIGITS-1:0]   o_digit_sel;
  logic                    o_frame_done;

  modport master (
    output i_output_enable,
    output i_load,
    output i_value,
    output i_dp_mask,
    output i_blank_lz,
    input  o_segments,
    input  o_dp,
    input  o_digit_sel,
    input  o_frame_done
  );

  modport slave (
    input  i_output_enable,
    input  i_load,
    input  i_value,
    input  i_dp_mask,
    input  i_blank_lz,
    output o_segments,
    output o_dp,
    output o_digit_sel,
    output o_frame_done
  );

endinterface

// File: rtl/mest_pro_mux_display.sv
// Time-multiplexed seven-segment display driver for the MESTPro output stage.
// A shadow copy of the packed hex value is scanned one digit per scan slot;
// each slot drives a one-hot digit select, decoded segments and a decimal
// point, with optional leading-zero blanking and a global output blank.
// All outputs are registered, so they show the index/shadow state one cycle
// after it was reached.
module mest_pro_mux_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_WIDTH = 4,
  parameter int SEG_WIDTH   = 7,
  parameter int SCAN_DIV    = 1000
) (
  input logic                   clk,
  input logic                   i_rst_n,
  mest_pro_mux_display_if.slave bus
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Unsupported geometries are rejected while elaborating.
  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("mest_pro_mux_display: NUM_DIGITS must be in 1..8");
    end
    if (DIGIT_WIDTH != 4) begin : g_bad_digit_width
      $error("mest_pro_mux_display: DIGIT_WIDTH must be 4");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
      $error("mest_pro_mux_display: SCAN_DIV must be >= 1");
    end
  endgenerate

  // Hex nibble to a..g segment pattern, a in the MSB.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h73;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
    endcase
    return seg;
  endfunction

  logic [NUM_DIGITS*4-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp_mask;
  logic [PRE_W-1:0]        r_pre;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_wrap;
  logic [SEG_WIDTH-1:0]    r_segments;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_digit_sel;
  logic                    r_frame_done;

  logic                    w_tc;
  logic                    w_wrap;
  logic [NUM_DIGITS-1:0]   w_lz_vec;
  logic [3:0]              w_nibble;
  logic                    w_dp_bit;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_onehot;

  assign w_tc   = (r_pre == PRE_LAST);
  assign w_wrap = w_tc && (r_idx == IDX_LAST);

  // Shadow registers: a load is accepted whenever out of reset, display on or off.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_value   <= '0;
      r_dp_mask <= '0;
    end else if (bus.i_load) begin
      r_value   <= bus.i_value;
      r_dp_mask <= bus.i_dp_mask;
    end
  end

  // Prescaler and digit index keep scanning regardless of the output enable.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap;
      if (w_tc) begin
        r_pre <= '0;
        if (r_idx == IDX_LAST) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // Marks every digit k>0 that, together with all digits above it, holds zero.
  always_comb begin : p_leading_zero
    logic run_zero;
    run_zero = 1'b1;
    w_lz_vec = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run_zero    = run_zero & (r_value[k*4 +: 4] == 4'h0);
      w_lz_vec[k] = run_zero & (k != 0);
    end
  end

  // Selects the nibble, decimal point and blank flag of the current digit.
  always_comb begin
    w_nibble = 4'h0;
    w_dp_bit = 1'b0;
    w_blank  = 1'b0;
    w_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble    = r_value[k*4 +: 4];
        w_dp_bit    = r_dp_mask[k];
        w_blank     = bus.i_blank_lz & w_lz_vec[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  // Output register; the frame strobe follows the wrap so it lines up with digit 0 reappearing.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_segments   <= '0;
      r_dp         <= 1'b0;
      r_digit_sel  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_wrap;
      if (bus.i_output_enable) begin
        r_segments  <= w_blank ? '0 : SEG_WIDTH'(f_decode(w_nibble));
        r_dp        <= w_dp_bit;
        r_digit_sel <= w_onehot;
      end else begin
        r_segments  <= '0;
        r_dp        <= 1'b0;
        r_digit_sel <= '0;
      end
    end
  end

  assign bus.o_segments   = r_segments;
  assign bus.o_dp         = r_dp;
  assign bus.o_digit_sel  = r_digit_sel;
  assign bus.o_frame_done = r_frame_done;

endmodule

// File: tb/tb_mest_pro_mux_display.sv
// Self-checking bench for mest_pro_mux_display (4 digits, 4-cycle scan slot).
// Expected outputs come from a cycle-count model: the digit shown after the
// t-th edge since reset release is ((t-1)/SCAN_DIV) mod NUM_DIGITS, using the
// shadow value captured before that edge.
module tb_mest_pro_mux_display;

  localparam int NUM_DIGITS = 4;
  localparam int SCAN_DIV   = 4;
  localparam int SEG_WIDTH  = 7;
  localparam int FRAME_LEN  = NUM_DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic rstN;

  mest_pro_mux_display_if #(.NUM_DIGITS(NUM_DIGITS), .SEG_WIDTH(SEG_WIDTH)) bus ();

  mest_pro_mux_display #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_WIDTH(4),
    .SEG_WIDTH  (SEG_WIDTH),
    .SCAN_DIV   (SCAN_DIV)
  ) dut (
    .clk    (clk),
    .i_rst_n(rstN),
    .bus    (bus)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  logic [6:0] segTable [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int assertCount = 0;
  int failCount   = 0;

  logic [NUM_DIGITS*4-1:0] mValue;
  logic [NUM_DIGITS-1:0]   mMask;
  int                      mT;

  logic [SEG_WIDTH-1:0]    expSeg;
  logic                    expDp;
  logic [NUM_DIGITS-1:0]   expSel;
  logic                    expFd;

  task automatic applyStimulus(input logic rst, input logic en, input logic load,
                               input logic [15:0] value, input logic [3:0] mask,
                               input logic blz);
    rstN                = rst;
    bus.i_output_enable = en;
    bus.i_load          = load;
    bus.i_value         = value;
    bus.i_dp_mask       = mask;
    bus.i_blank_lz      = blz;
  endtask

  // Predict the outputs of the coming edge, advance the model, then wait past the edge.
  task automatic tick();
    int idx;
    logic [3:0] nib;
    logic blank;
    if (!rstN) begin
      expSeg = '0;
      expDp  = 1'b0;
      expSel = '0;
      expFd  = 1'b0;
    end else begin
      idx   = (mT / SCAN_DIV) % NUM_DIGITS;
      nib   = 4'((mValue >> (idx * 4)) & 16'h000F);
      blank = bus.i_blank_lz && (idx != 0) && ((mValue >> (idx * 4)) == 16'h0000);
      expFd = (mT > 0) && ((mT % FRAME_LEN) == 0);
      if (bus.i_output_enable) begin
        expSel = 4'(1 << idx);
        expDp  = mMask[idx];
        expSeg = blank ? 7'h00 : segTable[nib];
      end else begin
        expSel = '0;
        expDp  = 1'b0;
        expSeg = '0;
      end
    end
    if (!rstN) begin
      mValue = '0;
      mMask  = '0;
      mT     = 0;
    end else begin
      if (bus.i_load) begin
        mValue = bus.i_value;
        mMask  = bus.i_dp_mask;
      end
      mT++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    assertCount++;
    assert (bus.o_segments === expSeg) else begin
      failCount++;
      $error("[TB] FAIL %s seg: got %h expected %h (t=%0d)", tag, bus.o_segments, expSeg, mT);
    end
    assertCount++;
    assert (bus.o_dp === expDp) else begin
      failCount++;
      $error("[TB] FAIL %s dp: got %b expected %b (t=%0d)", tag, bus.o_dp, expDp, mT);
    end
    assertCount++;
    assert (bus.o_digit_sel === expSel) else begin
      failCount++;
      $error("[TB] FAIL %s sel: got %b expected %b (t=%0d)", tag, bus.o_digit_sel, expSel, mT);
    end
    assertCount++;
    assert (bus.o_frame_done === expFd) else begin
      failCount++;
      $error("[TB] FAIL %s frame_done: got %b expected %b (t=%0d)", tag, bus.o_frame_done, expFd, mT);
    end
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(tag);
    end
  endtask

  // Directed scenarios followed by a randomized soak, all against the model.
  initial begin
    mValue = '0;
    mMask  = '0;
    mT     = 0;

    // Reset held with a load pending: the load must not reach the shadow.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0000, 1'b0);
    runCycles(3, "reset");

    // First edge after release shows digit 0 of the cleared shadow.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    runCycles(1, "release");
    assertCount++;
    assert (bus.o_digit_sel === 4'b0001 && bus.o_segments === 7'h7E) else begin
      failCount++;
      $error("[TB] FAIL first_digit: got sel %b seg %h expected sel 0001 seg 7e",
             bus.o_digit_sel, bus.o_segments);
    end

    // Scan and decode of 1234 with a decimal point on digit 2.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234, 4'b0100, 1'b0);
    runCycles(1, "scan_load");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    runCycles(2 * FRAME_LEN + 8, "scan");

    // Every hex value replicated across all digits.
    for (int v = 0; v < 16; v++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, {4{4'(v)}}, 4'(v), 1'b0);
      runCycles(1, "sweep_load");
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
      runCycles(FRAME_LEN, "sweep");
    end

    // Leading-zero blanking on 0050, then on all zeros.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0050, 4'b1000, 1'b1);
    runCycles(1, "lz_load");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1);
    runCycles(FRAME_LEN + 4, "lz_0050");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 4'b0001, 1'b1);
    runCycles(1, "lz_load0");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1);
    runCycles(FRAME_LEN + 4, "lz_0000");

    // Global blank mid-scan, frame strobe keeps going, then resume.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h9876, 4'b0011, 1'b0);
    runCycles(6, "gblank_pre");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0);
    runCycles(2 * FRAME_LEN + 3, "gblank_off");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    runCycles(FRAME_LEN, "gblank_on");

    // Load coinciding with the prescaler terminal count.
    for (int i = 0; i < SCAN_DIV && (mT % SCAN_DIV) != SCAN_DIV - 1; i++) begin
      runCycles(1, "collide_align");
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hABCD, 4'b1010, 1'b0);
    runCycles(1, "collide_load");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    runCycles(SCAN_DIV * 2, "collide");

    // Reset in the middle of digit 2, then restart from digit 0.
    for (int i = 0; i < FRAME_LEN && !(((mT / SCAN_DIV) % NUM_DIGITS) == 2 && (mT % SCAN_DIV) == 1); i++) begin
      runCycles(1, "midreset_align");
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    runCycles(1, "midreset");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    runCycles(FRAME_LEN + 2, "after_reset");

    // Randomized soak over every input.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom),
                    1'($urandom));
      runCycles(1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
